ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Receives the raw PS/2 keyboard serial stream, deframes 11-bit PS/2 frames, and collapses the `E0`/`F0` prefix bytes into one event per key action. Each event is a single-cycle `valid` pulse carrying the scan code, a make/break flag and an extended flag. The block sits directly upstream of the player-input decoder, which consumes `valid`, `makeBreak` and `outCode`. It replaces the keyboard press driver and adds parity checking, glitch filtering and mid-frame timeout recovery.

## Interface

Parameters:
- `FILTER_LEN`, default 8: number of consecutive `clk` cycles the synchronized `PS2_CLK` must hold a new level before the filtered level changes.
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles allowed between falling edges inside a frame before the frame is aborted (2 ms at 50 MHz).

Ports:
- `clk`  input  1  system clock (50 MHz). Only clock; every register is on its rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `PS2_CLK`  input  1  raw PS/2 clock, asynchronous to `clk`.
- `PS2_DAT`  input  1  raw PS/2 data, asynchronous to `clk`.
- `valid`  output  1  one-cycle pulse: event fields are valid this cycle.
- `makeBreak`  output  1  1 = key pressed (make), 0 = key released (break).
- `outCode`  output  8  scan code, prefixes removed.
- `extended`  output  1  1 = event was preceded by `E0`.
- `frame_err`  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation

Input conditioning:
- `PS2_CLK` and `PS2_DAT` each pass through a 2-flop synchronizer.
- Glitch filter: a counter runs while the synchronized `PS2_CLK` differs from the filtered level. When the difference has persisted for `FILTER_LEN` cycles, the filtered level updates. The counter clears whenever the two levels match.
- Falling edge (`fe`): the filtered level goes from 1 to 0. `fe` is high for one cycle. The synchronized `PS2_DAT` is sampled in the `fe` cycle.

Frame FSM (states `IDLE`, `DATA`, `PARITY`, `STOP`):
- `IDLE`:
  - `fe` with data = 0 (start bit): go to `DATA`, clear the bit counter.
  - `fe` with data = 1: ignore and stay in `IDLE`.
- `DATA`:
  - On each `fe`, shift the data bit into the shift register, LSB first.
  - After the 8th bit, go to `PARITY`.
- `PARITY`:
  - On `fe`, store the parity bit and go to `STOP`.
  - Parity is good when (XOR of the 8 data bits) XOR (parity bit) = 1, i.e. odd parity.
- `STOP`:
  - On `fe`, return to `IDLE`.
  - Stop bit = 1 and parity good: the byte is accepted.
  - Otherwise: pulse `frame_err`, discard the byte, clear both prefix flags.
- Timeout:
  - A counter clears on every `fe` and counts in all non-`IDLE` states.
  - When it reaches `TIMEOUT_CYCLES`: return to `IDLE`, pulse `frame_err`, clear both prefix flags, discard the partial byte.

Prefix handling (runs on each accepted byte):
- `E0`: set `ext_flag`. No event.
- `F0`: set `brk_flag`. No event.
- Any other byte:
  - Pulse `valid`, with `outCode` = byte, `makeBreak` = ~`brk_flag`, `extended` = `ext_flag`.
  - Then clear both flags.
- Bytes `E1`, `FA` and `AA` are ordinary bytes and produce events.

Output hold:
- `outCode`, `makeBreak` and `extended` hold their last values until the next event.

Reset (`reset_n` = 0 at a rising edge of `clk`):
- All outputs go to 0.
- FSM goes to `IDLE`; both prefix flags and all counters clear.
- Filtered `PS2_CLK` and both synchronizer stages are set to 1, the idle bus level.
- Reset mid-frame discards the partial frame. The remaining bits of that frame are ignored until a later start bit is seen in `IDLE`.

## Timing

- Synchronizer latency is 2 cycles. Filter latency is `FILTER_LEN` cycles, so a raw `PS2_CLK` fall produces `fe` 2 + `FILTER_LEN` cycles later.
- `valid` or `frame_err` goes high in the cycle after the stop-bit `fe` and stays high for exactly one cycle.
- `valid` and `frame_err` are never high in the same cycle.
- A timeout `frame_err` is asserted in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- An `fe` arriving on the same cycle as the timeout is lost: the timeout wins and the FSM is in `IDLE`.
- Back-to-back frames need no gap. The first `fe` after the stop bit may be the next start bit.

## Test plan

- Make A: one frame `1C` (parity 0) -> one `valid` pulse with `outCode`=`1C`, `makeBreak`=1, `extended`=0. No `frame_err`.
- Break A: frames `F0`, `1C` -> exactly one `valid`, with `outCode`=`1C`, `makeBreak`=0, `extended`=0.
- Extended arrows: frames `E0 75`, then `E0 F0 75` -> two events. First: `75`, `makeBreak`=1, `extended`=1. Second: `75`, `makeBreak`=0, `extended`=1. Then a plain `1D` -> `extended`=0.
- Parity error: frame `1C` with parity bit 1 -> `frame_err` pulse and no `valid`. A following good `1B` -> normal event.
- Glitch and timeout:
  - A 3-cycle low glitch on `PS2_CLK` -> no `fe`, no state change.
  - Stop the clock after 5 data bits -> `frame_err` exactly `TIMEOUT_CYCLES` cycles (+1) after the last `fe`.
  - The next full `23` frame -> `valid` with `outCode`=`23`.
- Reset mid-frame: `E0` accepted, then `reset_n` low after 4 bits of the next frame -> all outputs 0. A later full `6B` frame -> `extended`=0, `makeBreak`=1.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Deframes the PS/2 keyboard serial stream (start, 8 data LSB first, odd
//   parity, stop) and folds the E0/F0 prefix bytes into one event per key
//   action.
//
// Ports
//   clk        in   system clock, every register on its rising edge
//   reset_n    in   synchronous active-low reset
//   PS2_CLK    in   raw PS/2 clock (asynchronous)
//   PS2_DAT    in   raw PS/2 data  (asynchronous)
//   valid      out  one-cycle event strobe
//   makeBreak  out  1 = make, 0 = break (held until next event)
//   outCode    out  scan code without prefixes (held until next event)
//   extended   out  event was preceded by E0 (held until next event)
//   frame_err  out  one-cycle pulse on parity/stop error or timeout
module ps2_scancode_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       valid,
    output logic       makeBreak,
    output logic [7:0] outCode,
    output logic       extended,
    output logic       frame_err
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_clk_s1, r_clk_s2;
    logic                r_dat_s1, r_dat_s2;
    logic                r_filt, r_filt_d;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [7:0]          r_shift;
    logic [2:0]          r_bitcnt;
    logic                r_parity;
    logic                r_ext, r_brk;

    logic                w_fe;
    logic                w_timeout;
    logic                w_shift_en;
    logic                w_clr_bits;
    logic                w_par_ld;
    logic                w_byte_ok;
    logic                w_byte_bad;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    assign w_fe      = r_filt_d & ~r_filt;
    assign w_timeout = (r_state != IDLE) && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES));

    // Synchronizers, glitch filter, edge history and timeout counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fcnt   <= '0;
            r_tcnt   <= '0;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt;
            // Filtered level flips only after FILTER_LEN consecutive differing cycles.
            if (r_clk_s2 != r_filt) begin
                if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
                    r_filt <= r_clk_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end else begin
                r_fcnt <= '0;
            end
            if (r_state == IDLE || w_fe || w_timeout) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_clr_bits   = 1'b0;
        w_par_ld     = 1'b0;
        w_byte_ok    = 1'b0;
        w_byte_bad   = 1'b0;
        if (w_timeout) begin
            // Timeout beats a coincident edge; that edge is dropped.
            w_state_next = IDLE;
            w_byte_bad   = 1'b1;
        end else if (w_fe) begin
            unique case (r_state)
                IDLE: begin
                    if (!r_dat_s2) begin
                        w_state_next = DATA;
                        w_clr_bits   = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = PARITY;
                    end
                end
                PARITY: begin
                    w_par_ld     = 1'b1;
                    w_state_next = STOP;
                end
                STOP: begin
                    w_state_next = IDLE;
                    if (r_dat_s2 && parity_ok(r_shift, r_parity)) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_byte_bad = 1'b1;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Frame bit counter (control) and received data (no reset needed)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bitcnt <= '0;
        end else if (w_clr_bits) begin
            r_bitcnt <= '0;
        end else if (w_shift_en) begin
            r_bitcnt <= r_bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_shift_en) begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
        end
        if (w_par_ld) begin
            r_parity <= r_dat_s2;
        end
    end

    // Prefix folding and event outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            outCode   <= '0;
            makeBreak <= 1'b0;
            extended  <= 1'b0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (w_byte_bad) begin
                frame_err <= 1'b1;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
            end else if (w_byte_ok) begin
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    valid     <= 1'b1;
                    outCode   <= r_shift;
                    makeBreak <= ~r_brk;
                    extended  <= r_ext;
                    r_ext     <= 1'b0;
                    r_brk     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed cases plus randomized frames
// checked against a byte-level reference model of the prefix rules.
module tb_ps2_scancode_decoder;

    localparam int FL = 4;
    localparam int TO = 2000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       valid, makeBreak, extended, frame_err;
    logic [7:0] outCode;

    ps2_scancode_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .valid(valid), .makeBreak(makeBreak), .outCode(outCode),
        .extended(extended), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         mb;
        bit         ext;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         n_events = 0;
    int         hp = 16;
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_mb = 0;
    bit         m_xt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: what one received byte means at the event level.
    task automatic model_byte(input logic [7:0] b, input bit bad);
        ev_t e;
        if (bad) begin
            e = '{is_err: 1'b1, code: 8'h00, mb: 1'b0, ext: 1'b0};
            exp_q.push_back(e);
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e = '{is_err: 1'b0, code: b, mb: !m_brk, ext: m_ext};
            exp_q.push_back(e);
            m_code = b;
            m_mb   = !m_brk;
            m_xt   = m_ext;
            m_ext  = 0;
            m_brk  = 0;
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (hp) @(negedge clk);
        PS2_CLK = 1'b0;
        t_fall  = cyc;
        repeat (hp) @(negedge clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic perr, input logic stop_b);
        model_byte(b, perr || !stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ perr);
        ps2_bit(stop_b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Event monitor: every strobe must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (reset_n) begin
            if (valid && frame_err) check_eq("both_strobes", 1, 0);
            if (valid || frame_err) begin
                n_events++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", {outCode, 7'd0, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("event_kind", frame_err, e.is_err);
                    if (!e.is_err) begin
                        check_eq("outCode", outCode, e.code);
                        check_eq("makeBreak", makeBreak, e.mb);
                        check_eq("extended", extended, e.ext);
                    end
                end
            end
        end
    end

    initial begin
        int ev0;
        int lat;
        logic [7:0] b;
        int r;

        repeat (5) @(negedge clk);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_outCode", outCode, 0);
        check_eq("rst_makeBreak", makeBreak, 0);
        check_eq("rst_extended", extended, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Make, break, extended arrows, plain key
        send_frame(8'h1C, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1C, 0, 1);
        send_frame(8'hE0, 0, 1);
        send_frame(8'h75, 0, 1);
        send_frame(8'hE0, 0, 1);
        send_frame(8'hF0, 0, 1);
        send_frame(8'h75, 0, 1);
        send_frame(8'h1D, 0, 1);
        drain("drain_basic");

        // Parity error then good byte
        send_frame(8'h1C, 1, 1);
        send_frame(8'h1B, 0, 1);
        drain("drain_parity");

        // Short low glitch with data low must not start a frame
        ev0 = n_events;
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        repeat (3) @(negedge clk);
        PS2_CLK = 1'b1;
        repeat (40) @(negedge clk);
        PS2_DAT = 1'b1;
        check_eq("glitch_no_event", n_events - ev0, 0);

        // Clock stops after 5 data bits
        b = 8'h3A;
        model_byte(b, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(b[i]);
        for (int i = 0; i < TO + 100 && !frame_err; i++) @(negedge clk);
        check_eq("timeout_seen", frame_err, 1);
        lat = cyc - t_fall;
        check_eq("timeout_latency", (lat >= FL + TO + 2) && (lat <= FL + TO + 6), 1);
        repeat (10) @(negedge clk);
        send_frame(8'h23, 0, 1);
        drain("drain_timeout");

        // Reset mid-frame after an accepted E0
        send_frame(8'hE0, 0, 1);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        m_ext = 0; m_brk = 0; m_code = 8'h00; m_mb = 0; m_xt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_outCode", outCode, 0);
        check_eq("mid_rst_makeBreak", makeBreak, 0);
        check_eq("mid_rst_extended", extended, 0);
        check_eq("mid_rst_strobes", {valid, frame_err}, 0);
        repeat (20) @(negedge clk);
        send_frame(8'h6B, 0, 1);
        drain("drain_reset");

        // Randomized traffic, varying bit rate, gaps, parity and stop faults
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = 8'hE0;
            else if (r < 40) b = 8'hF0;
            else             b = 8'($urandom);
            hp = $urandom_range(12, 25);
            send_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) != 0));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        drain("drain_random");

        // Event fields hold the last event
        repeat (50) @(negedge clk);
        check_eq("hold_outCode", outCode, m_code);
        check_eq("hold_makeBreak", makeBreak, m_mb);
        check_eq("hold_extended", extended, m_xt);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #(20 * 90000);
        n_errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
